uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 89 ++++++++
 tb/tb_uart_tx_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one byte per accepted i_Tx_DV strobe, start bit, 8 data bits LSB first, stop bit.
// Each bit lasts CLKS_PER_BIT clocks. All outputs are registered and the line idles high.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    if (i_Tx_DV) begin
                        shift_reg   <= i_Tx_Byte;
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (clk_cnt == LAST_CLK) begin
                        clk_cnt     <= '0;
                        o_Tx_Serial <= shift_reg[0];
                        state       <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // The latched byte shifts right so the bit on the line is always shift_reg[0].
                DATA: begin
                    if (clk_cnt == LAST_CLK) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_Tx_Serial <= 1'b1;
                            state       <= STOP;
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            o_Tx_Serial <= shift_reg[1];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == LAST_CLK) begin
                        clk_cnt     <= '0;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Done   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=10 (dut) and CLKS_PER_BIT=2 (dut2).
// Outputs are compared as {active, serial, done} at every falling edge.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv, dv2;
    logic [7:0] tx_byte, tx_byte2;
    logic       active, serial, done;
    logic       active2, serial2, done2;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(10)) dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Tx_DV    (dv),
        .i_Tx_Byte  (tx_byte),
        .o_Tx_Active(active),
        .o_Tx_Serial(serial),
        .o_Tx_Done  (done)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(2)) dut2 (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Tx_DV    (dv2),
        .i_Tx_Byte  (tx_byte2),
        .o_Tx_Active(active2),
        .o_Tx_Serial(serial2),
        .o_Tx_Done  (done2)
    );

    task automatic test_reset();
        rst_n = 1'b0; dv = 1'b0; dv2 = 1'b0; tx_byte = 8'h00; tx_byte2 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                dv = 1'b1; tx_byte = 8'hFF; dv2 = 1'b1;
            end
            @(negedge clk);
            total_cnt++;
            if ({active, serial, done} !== 3'b010 || {active2, serial2, done2} !== 3'b010)
                $display("FAIL reset_hold cyc %0d: got %b/%b want 010/010", i,
                         {active, serial, done}, {active2, serial2, done2});
            else pass_cnt++;
        end
        dv = 1'b0; dv2 = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({active, serial, done} !== 3'b010 || {active2, serial2, done2} !== 3'b010)
                $display("FAIL reset_idle cyc %0d: got %b/%b want 010/010", i,
                         {active, serial, done}, {active2, serial2, done2});
            else pass_cnt++;
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] frame = {1'b1, 8'hA5, 1'b0};
        dv = 1'b1; tx_byte = 8'hA5;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin dv = 1'b0; tx_byte = 8'h00; end
            total_cnt++;
            if ({active, serial, done} !== {1'b1, frame[k/10], 1'b0})
                $display("FAIL frame_a5 k=%0d: got %b want %b", k, {active, serial, done},
                         {1'b1, frame[k/10], 1'b0});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({active, serial, done} !== 3'b011)
            $display("FAIL done_a5: got %b want 011", {active, serial, done});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({active, serial, done} !== 3'b010)
                $display("FAIL idle_after_a5 cyc %0d: got %b want 010", i, {active, serial, done});
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] f0 = {1'b1, 8'h00, 1'b0};
        logic [9:0] f1 = {1'b1, 8'hFF, 1'b0};
        dv = 1'b1; tx_byte = 8'h00;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            total_cnt++;
            if ({active, serial, done} !== {1'b1, f0[k/10], 1'b0})
                $display("FAIL frame_00 k=%0d: got %b want %b", k, {active, serial, done},
                         {1'b1, f0[k/10], 1'b0});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({active, serial, done} !== 3'b011)
            $display("FAIL done_00: got %b want 011", {active, serial, done});
        else pass_cnt++;
        dv = 1'b1; tx_byte = 8'hFF;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            total_cnt++;
            if ({active, serial, done} !== {1'b1, f1[k/10], 1'b0})
                $display("FAIL frame_ff k=%0d: got %b want %b", k, {active, serial, done},
                         {1'b1, f1[k/10], 1'b0});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({active, serial, done} !== 3'b011)
            $display("FAIL done_ff: got %b want 011", {active, serial, done});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({active, serial, done} !== 3'b010)
            $display("FAIL idle_after_ff: got %b want 010", {active, serial, done});
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        logic [9:0] frame = {1'b1, 8'h81, 1'b0};
        dv = 1'b1; tx_byte = 8'h81;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            total_cnt++;
            if ({active, serial, done} !== {1'b1, frame[k/10], 1'b0})
                $display("FAIL frame_81 k=%0d: got %b want %b", k, {active, serial, done},
                         {1'b1, frame[k/10], 1'b0});
            else pass_cnt++;
            if (k == 35) begin dv = 1'b1; tx_byte = 8'h3C; end
            if (k == 36) dv = 1'b0;
        end
        @(negedge clk);
        total_cnt++;
        if ({active, serial, done} !== 3'b011)
            $display("FAIL done_81: got %b want 011", {active, serial, done});
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({active, serial, done} !== 3'b010)
                $display("FAIL idle_after_81 cyc %0d: got %b want 010", i, {active, serial, done});
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] f0 = {1'b1, 8'h0F, 1'b0};
        logic [9:0] f1 = {1'b1, 8'h5A, 1'b0};
        dv = 1'b1; tx_byte = 8'h0F;
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            total_cnt++;
            if ({active, serial, done} !== {1'b1, f0[k/10], 1'b0})
                $display("FAIL frame_0f k=%0d: got %b want %b", k, {active, serial, done},
                         {1'b1, f0[k/10], 1'b0});
            else pass_cnt++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++;
        if ({active, serial, done} !== 3'b010)
            $display("FAIL abort_reset: got %b want 010", {active, serial, done});
        else pass_cnt++;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({active, serial, done} !== 3'b010)
                $display("FAIL no_done_after_abort cyc %0d: got %b want 010", i, {active, serial, done});
            else pass_cnt++;
        end
        dv = 1'b1; tx_byte = 8'h5A;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            total_cnt++;
            if ({active, serial, done} !== {1'b1, f1[k/10], 1'b0})
                $display("FAIL frame_5a k=%0d: got %b want %b", k, {active, serial, done},
                         {1'b1, f1[k/10], 1'b0});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({active, serial, done} !== 3'b011)
            $display("FAIL done_5a: got %b want 011", {active, serial, done});
        else pass_cnt++;
    endtask

    task automatic test_short_bit();
        logic [9:0] frame = {1'b1, 8'hC3, 1'b0};
        @(negedge clk);
        dv2 = 1'b1; tx_byte2 = 8'hC3;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin dv2 = 1'b0; tx_byte2 = 8'h00; end
            total_cnt++;
            if ({active2, serial2, done2} !== {1'b1, frame[k/2], 1'b0})
                $display("FAIL frame_c3 k=%0d: got %b want %b", k, {active2, serial2, done2},
                         {1'b1, frame[k/2], 1'b0});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({active2, serial2, done2} !== 3'b011)
            $display("FAIL done_c3: got %b want 011", {active2, serial2, done2});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({active2, serial2, done2} !== 3'b010)
            $display("FAIL idle_after_c3: got %b want 010", {active2, serial2, done2});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_short_bit();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
